// File: rtl/haze_add_cal_pkg.sv
// Shared constants and blend helper for the haze synthesis stage.
// Channel slices match the dehaze recovery stage pixel layout.
package haze_add_cal_pkg;
  localparam int PIX_W = 8;
  localparam int RGB_W = 24;
  localparam int T_ONE = 256;

  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [RGB_W-1:0] rgb_t;

  // Rounded >>8 of the two weighted terms; result fits 8 bits
  function automatic pix_t round_div(
    input logic [16:0] pj,
    input logic [16:0] pa
  );
    return pix_t'(({1'b0, pj} + {1'b0, pa} + 18'd128) >> 8);
  endfunction
endpackage

// File: rtl/haze_add_cal_if.sv
// Video bus bundle for haze_add_cal: src/tx inputs,
// hazy output stream and FIFO status.
interface haze_add_cal_if #(
  parameter int FIFO_AW = 4
);
  import haze_add_cal_pkg::*;

  logic             pre_src_frame_vsync;
  logic             pre_src_frame_href;
  logic             pre_src_frame_clken;
  rgb_t             pre_img;
  logic             pre_tx_frame_vsync;
  logic             pre_tx_frame_href;
  logic             pre_tx_frame_clken;
  pix_t             pre_tx_img;
  pix_t             pre_A;
  logic             post_frame_vsync;
  logic             post_frame_href;
  logic             post_frame_clken;
  rgb_t             post_img;
  logic             fifo_overflow;
  logic             fifo_underflow;
  logic [FIFO_AW:0] fifo_level;

  modport master (
    output pre_src_frame_vsync, pre_src_frame_href,
    output pre_src_frame_clken, pre_img,
    output pre_tx_frame_vsync, pre_tx_frame_href,
    output pre_tx_frame_clken, pre_tx_img, pre_A,
    input  post_frame_vsync, post_frame_href,
    input  post_frame_clken, post_img,
    input  fifo_overflow, fifo_underflow, fifo_level
  );

  modport slave (
    input  pre_src_frame_vsync, pre_src_frame_href,
    input  pre_src_frame_clken, pre_img,
    input  pre_tx_frame_vsync, pre_tx_frame_href,
    input  pre_tx_frame_clken, pre_tx_img, pre_A,
    output post_frame_vsync, post_frame_href,
    output post_frame_clken, post_img,
    output fifo_overflow, fifo_underflow, fifo_level
  );
endinterface

// File: rtl/haze_sync_fifo.sv
// Single-clock src pixel FIFO with same-cycle bypass when empty
// and overflow/underflow event pulses.
module haze_sync_fifo
  import haze_add_cal_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  rgb_t        wdata_i,
  input  logic        pop_i,
  output rgb_t        rdata_o,
  output logic [AW:0] level_o,
  output logic        ovf_o,
  output logic        udf_o
);
  localparam int LW = AW + 1;

  rgb_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;
  logic          full;
  logic          empty;
  logic          bypass;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == LW'(DEPTH));
    bypass  = empty & push_i & pop_i;
    do_push = push_i & (~full | pop_i) & ~bypass;
    do_pop  = pop_i & ~empty;
    ovf_o   = push_i & full & ~pop_i;
    udf_o   = pop_i & empty & ~push_i;
    rdata_o = bypass ? wdata_i : mem_q[rd_q];
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
endmodule

// File: rtl/haze_add_cal.sv
// Forward haze model I = J*t + A*(1-t): src FIFO alignment,
// frame-latched A, sticky FIFO flags and a 3-stage blend pipe.
module haze_add_cal
  import haze_add_cal_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input logic           clk,
  input logic           rst,
  haze_add_cal_if.slave io
);
  rgb_t             fifo_rdata;
  logic             fifo_ovf;
  logic             fifo_udf;

  logic             vs_q;
  logic             vs_rise;
  pix_t             a_q;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [2:0]       vs_sh_q;
  logic [2:0]       hr_sh_q;
  logic [2:0]       ck_sh_q;

  rgb_t             j_d, j1_q;
  logic [8:0]       t8_d, t8_q;
  pix_t             a1_q;
  logic [2:0][16:0] pj_d, pj_q;
  logic [16:0]      pa_d, pa_q;
  rgb_t             img_d, img_q;

  logic             unused_src_sync;
  assign unused_src_sync = ^{io.pre_src_frame_vsync,
                             io.pre_src_frame_href};

  haze_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (io.pre_src_frame_clken),
    .wdata_i (io.pre_img),
    .pop_i   (io.pre_tx_frame_clken),
    .rdata_o (fifo_rdata),
    .level_o (io.fifo_level),
    .ovf_o   (fifo_ovf),
    .udf_o   (fifo_udf)
  );

  always_comb begin
    vs_rise = io.pre_tx_frame_vsync & ~vs_q;
    ovf_d   = (vs_rise ? 1'b0 : ovf_q) | fifo_ovf;
    udf_d   = (vs_rise ? 1'b0 : udf_q) | fifo_udf;
    // Starved pop: J = A makes the blend return A exactly
    j_d     = fifo_udf ? {a_q, a_q, a_q} : fifo_rdata;
    t8_d    = (io.pre_tx_img == 8'hFF) ? 9'(T_ONE)
                                       : {1'b0, io.pre_tx_img};
    pj_d[2] = {9'd0, j1_q[R_MSB:R_LSB]} * {8'd0, t8_q};
    pj_d[1] = {9'd0, j1_q[G_MSB:G_LSB]} * {8'd0, t8_q};
    pj_d[0] = {9'd0, j1_q[B_MSB:B_LSB]} * {8'd0, t8_q};
    pa_d    = {9'd0, a1_q} * {8'd0, 9'(T_ONE) - t8_q};
    img_d   = {round_div(pj_q[2], pa_q),
               round_div(pj_q[1], pa_q),
               round_div(pj_q[0], pa_q)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q    <= 1'b0;
      a_q     <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      vs_sh_q <= '0;
      hr_sh_q <= '0;
      ck_sh_q <= '0;
      j1_q    <= '0;
      t8_q    <= '0;
      a1_q    <= '0;
      pj_q    <= '0;
      pa_q    <= '0;
      img_q   <= '0;
    end else begin
      vs_q    <= io.pre_tx_frame_vsync;
      if (vs_rise) a_q <= io.pre_A;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      vs_sh_q <= {vs_sh_q[1:0], io.pre_tx_frame_vsync};
      hr_sh_q <= {hr_sh_q[1:0], io.pre_tx_frame_href};
      ck_sh_q <= {ck_sh_q[1:0], io.pre_tx_frame_clken};
      if (io.pre_tx_frame_clken) begin
        j1_q <= j_d;
        t8_q <= t8_d;
        a1_q <= a_q;
      end
      if (ck_sh_q[0]) begin
        pj_q <= pj_d;
        pa_q <= pa_d;
      end
      if (ck_sh_q[1]) img_q <= img_d;
    end
  end

  assign io.post_frame_vsync = vs_sh_q[2];
  assign io.post_frame_href  = hr_sh_q[2];
  assign io.post_frame_clken = ck_sh_q[2];
  assign io.post_img         = img_q;
  assign io.fifo_overflow    = ovf_q;
  assign io.fifo_underflow   = udf_q;
endmodule

// File: tb/tb_haze_add_cal.sv
// Directed bench for haze_add_cal: blend values, latency,
// FIFO alignment/flags, A latching and async reset.
module tb_haze_add_cal;
  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          failures = 0;
  int          cyc_n = 0;
  int          lvl_max = 0;
  logic [23:0] outq[$];
  int          outc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  haze_add_cal_if #(.FIFO_AW(4)) bus();

  haze_add_cal #(.FIFO_DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always @(negedge clk) begin
    if (bus.post_frame_clken) begin
      outq.push_back(bus.post_img);
      outc.push_back(cyc_n);
    end
    if (int'(bus.fifo_level) > lvl_max)
      lvl_max = int'(bus.fifo_level);
  end

  function automatic logic [7:0] mdl(input int j, input int t,
                                     input int a);
    int t8;
    t8 = (t == 255) ? 256 : t;
    return 8'((j * t8 + a * (256 - t8) + 128) / 256);
  endfunction

  function automatic logic [23:0] mdl3(input logic [23:0] j,
                                       input int t, input int a);
    return {mdl(int'(j[23:16]), t, a),
            mdl(int'(j[15:8]), t, a),
            mdl(int'(j[7:0]), t, a)};
  endfunction

  function automatic logic [23:0] pix3(input int l, input int i);
    return {8'(l * 64 + i), 8'(i * 3), 8'(255 - i)};
  endfunction

  function automatic logic [23:0] pix4(input int k);
    return {8'(k), 8'(k + 32), 8'(k + 128)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.pre_src_frame_clken = 1'b0;
    bus.pre_src_frame_href  = 1'b0;
    bus.pre_tx_frame_clken  = 1'b0;
    bus.pre_tx_frame_href   = 1'b0;
  endtask

  task automatic step(input logic push, input logic [23:0] j,
                      input logic pop, input logic [7:0] t);
    bus.pre_src_frame_clken = push;
    bus.pre_src_frame_href  = push;
    bus.pre_img             = j;
    bus.pre_tx_frame_clken  = pop;
    bus.pre_tx_frame_href   = pop;
    bus.pre_tx_img          = t;
    @(posedge clk); #1;
  endtask

  task automatic vs_pulse(input logic [7:0] a);
    idle_in();
    bus.pre_A = a;
    bus.pre_tx_frame_vsync = 1'b1;
    @(posedge clk); #1;
    bus.pre_tx_frame_vsync = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic expect_img(input string tag, input logic [23:0] exp,
                            output int c);
    logic [23:0] img;
    int n;
    n = 0;
    while (outq.size() == 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (outq.size() != 0) begin
      img = outq.pop_front();
      c = outc.pop_front();
    end else begin
      img = 'x;
      c = -1;
    end
    chk(tag, {8'd0, img}, {8'd0, exp});
  endtask

  initial begin
    logic [23:0] jv;
    logic [23:0] mj [8];
    logic [7:0]  mt [8];
    int          c, c0;

    rst = 1'b1;
    bus.pre_src_frame_vsync = 1'b0;
    bus.pre_tx_frame_vsync  = 1'b0;
    bus.pre_img    = '0;
    bus.pre_tx_img = '0;
    bus.pre_A      = '0;
    idle_in();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_img", bus.post_img, 0);
    chk("rst_sync", {bus.post_frame_vsync, bus.post_frame_href,
                     bus.post_frame_clken}, 0);
    chk("rst_flags", {bus.fifo_overflow, bus.fifo_underflow}, 0);
    chk("rst_level", bus.fifo_level, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single coincident pixel, latency
    vs_pulse(8'd220);
    c0 = cyc_n;
    step(1'b1, 24'hC86432, 1'b1, 8'd128);
    idle_in();
    expect_img("t1_img", 24'hD2A087, c);
    chk("t1_lat", c - c0, 3);
    chk("t1_level", bus.fifo_level, 0);

    // 2: t=255 passes J, t=0 gives A, plus model points
    vs_pulse(8'd17);
    for (int j = 0; j < 256; j++) begin
      jv = {8'(j), ~8'(j), 8'(j) ^ 8'h5A};
      step(1'b1, jv, 1'b1, 8'd255);
    end
    for (int j = 0; j < 256; j++) begin
      jv = {8'(j), ~8'(j), 8'(j) ^ 8'h5A};
      step(1'b1, jv, 1'b1, 8'd0);
    end
    for (int k = 0; k < 8; k++) begin
      mj[k] = 24'(k * 24'h1F3B77 + 24'h0A0B0C);
      mt[k] = 8'(k * 37 + 1);
      step(1'b1, mj[k], 1'b1, mt[k]);
    end
    idle_in();
    for (int j = 0; j < 256; j++) begin
      jv = {8'(j), ~8'(j), 8'(j) ^ 8'h5A};
      expect_img("t2_t255", jv, c);
    end
    for (int j = 0; j < 256; j++)
      expect_img("t2_t0", 24'h111111, c);
    for (int k = 0; k < 8; k++)
      expect_img("t2_model", mdl3(mj[k], int'(mt[k]), 17), c);
    chk("t2_flags", {bus.fifo_overflow, bus.fifo_underflow}, 0);

    // 3: 64x4 frame, src leads tx by 5, A changed mid-frame
    vs_pulse(8'd60);
    lvl_max = 0;
    for (int l = 0; l < 4; l++) begin
      if (l == 2) bus.pre_A = 8'd99;
      for (int i = 0; i < 69; i++)
        step(i < 64, pix3(l, i), i >= 5, 8'd200);
      idle_in();
      chk("t3_level_eol", bus.fifo_level, 0);
      @(posedge clk); #1;
    end
    chk("t3_peak", lvl_max, 5);
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 64; i++)
        expect_img("t3_pix", mdl3(pix3(l, i), 200, 60), c);
    chk("t3_flags", {bus.fifo_overflow, bus.fifo_underflow}, 0);
    vs_pulse(8'd99);
    step(1'b1, 24'h102030, 1'b1, 8'd0);
    idle_in();
    expect_img("t3_newA", 24'h636363, c);

    // 4: overflow, full push+pop, drain
    vs_pulse(8'd0);
    for (int k = 1; k <= 16; k++)
      step(1'b1, pix4(k), 1'b0, 8'd0);
    idle_in();
    chk("t4_ovf_at16", bus.fifo_overflow, 0);
    chk("t4_level16", bus.fifo_level, 16);
    step(1'b1, pix4(17), 1'b0, 8'd0);
    idle_in();
    chk("t4_ovf", bus.fifo_overflow, 1);
    chk("t4_level_full", bus.fifo_level, 16);
    vs_pulse(8'd0);
    chk("t4_ovf_clr", bus.fifo_overflow, 0);
    step(1'b1, 24'hEEEEEE, 1'b1, 8'd255);
    idle_in();
    chk("t4_full_pp_lvl", bus.fifo_level, 16);
    chk("t4_full_pp_ovf", bus.fifo_overflow, 0);
    for (int k = 0; k < 16; k++)
      step(1'b0, 24'h0, 1'b1, 8'd255);
    idle_in();
    for (int k = 1; k <= 16; k++)
      expect_img("t4_pix", pix4(k), c);
    expect_img("t4_last", 24'hEEEEEE, c);
    repeat (6) @(posedge clk);
    #1;
    chk("t4_no_extra", outq.size(), 0);
    chk("t4_level0", bus.fifo_level, 0);
    chk("t4_udf", bus.fifo_underflow, 0);

    // 5: underflow substitute, then bypass
    vs_pulse(8'd90);
    step(1'b0, 24'h0, 1'b1, 8'd0);
    idle_in();
    chk("t5_udf", bus.fifo_underflow, 1);
    expect_img("t5_subst", 24'h5A5A5A, c);
    vs_pulse(8'd90);
    chk("t5_udf_clr", bus.fifo_underflow, 0);
    step(1'b1, 24'h0A141E, 1'b1, 8'd255);
    idle_in();
    expect_img("t5_bypass", 24'h0A141E, c);
    chk("t5_noflag", {bus.fifo_overflow, bus.fifo_underflow}, 0);
    chk("t5_level", bus.fifo_level, 0);

    // 6: async reset with data buffered and a pixel in flight
    for (int k = 1; k <= 8; k++)
      step(1'b1, pix4(k), 1'b0, 8'd0);
    idle_in();
    chk("t6_level8", bus.fifo_level, 8);
    step(1'b0, 24'h0, 1'b1, 8'd255);
    idle_in();
    rst = 1'b1;
    #1;
    chk("t6_rst_img", bus.post_img, 0);
    chk("t6_rst_ck", bus.post_frame_clken, 0);
    chk("t6_rst_lvl", bus.fifo_level, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_aborted", outq.size(), 0);
    c0 = cyc_n;
    step(1'b0, 24'h0, 1'b1, 8'd128);
    idle_in();
    expect_img("t6_A_zero", 24'h000000, c);
    chk("t6_lat", c - c0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
